obstacle_scheduler: RTL

- Sequences the cactus obstacle datapath: owns four obstacle slots, the movement tick, the speed ramp and randomised spawn spacing.
- Runs a game-state FSM (IDLE/RUN/OVER) and drives the renderer with slot positions plus a one-cycle sync pulse per movement step.
- Sits between the random source / collision logic and the drawing logic.

---
 rtl/obstacle_scheduler_if.sv | 24 ++
 rtl/obstacle_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler_if.sv
// rtl/obstacle_scheduler_if.sv - game-control and renderer signals of the obstacle scheduler
interface obstacle_scheduler_if;
   logic        start;
   logic        game_over;
   logic [8:0]  random_input;
   logic [11:0] cactus0;
   logic [11:0] cactus1;
   logic [11:0] cactus2;
   logic [11:0] cactus3;
   logic [3:0]  cactus_active;
   logic        cactus_sync;
   logic [1:0]  state;
   logic [17:0] period;

   modport master (
      input  start, game_over, random_input,
      output cactus0, cactus1, cactus2, cactus3, cactus_active, cactus_sync, state, period
   );

   modport slave (
      output start, game_over, random_input,
      input  cactus0, cactus1, cactus2, cactus3, cactus_active, cactus_sync, state, period
   );
endinterface

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - cactus obstacle sequencer: four slots, movement tick, speed ramp, spawn spacing
// Game FSM IDLE/RUN/OVER gates all datapath updates; renderer gets a one-cycle sync after each move.
module obstacle_scheduler #(
   parameter int START_PERIOD = 200000,
   parameter int MIN_PERIOD   = 50000,
   parameter int PERIOD_STEP  = 10000,
   parameter int RAMP_CYCLES  = 180000000,
   parameter int SCREEN_END   = 1074,
   parameter int SPAWN_X      = 4046,
   parameter int MIN_GAP      = 300
) (
   input logic                  clk,
   input logic                  rst,
   obstacle_scheduler_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

   localparam int                RAMP_W     = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [17:0]       START_P    = 18'(START_PERIOD);
   localparam logic [17:0]       MIN_P      = 18'(MIN_PERIOD);
   localparam logic [17:0]       STEP_P     = 18'(PERIOD_STEP);
   localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_CYCLES - 1);
   localparam logic [11:0]       RETIRE_POS = 12'(SCREEN_END - 1);
   localparam logic [11:0]       SPAWN_POS  = 12'(SPAWN_X);
   localparam logic [9:0]        GAP_MIN    = 10'(MIN_GAP);
   localparam logic [9:0]        GAP_SAT    = 10'd1023;

   state_t             state_q, state_d;
   logic               game_init, run_step, tick_fire, ramp_fire, spawn_en, sync_q;
   logic [17:0]        period_q, tick_cnt, period_ramped;
   logic [RAMP_W-1:0]  ramp_cnt;
   logic [9:0]         gap_cnt, req_gap, gap_inc;
   logic [3:0][11:0]   pos_q, pos_mv;
   logic [3:0]         active_q, active_mv;
   logic [1:0]         spawn_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // game_over in RUN freezes everything on that edge, including a tick that was due
   always_comb begin
      state_d   = state_q;
      game_init = 1'b0;
      run_step  = 1'b0;
      case (state_q)
         IDLE, OVER: if (bus.start) begin
            state_d   = RUN;
            game_init = 1'b1;
         end
         RUN: if (bus.game_over) state_d = OVER;
              else               run_step = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   assign tick_fire     = run_step && (tick_cnt >= period_q - 18'd1);
   assign ramp_fire     = run_step && (ramp_cnt == RAMP_LAST);
   assign period_ramped = (period_q >= MIN_P + STEP_P) ? period_q - STEP_P : MIN_P;
   assign gap_inc       = (gap_cnt == GAP_SAT) ? GAP_SAT : gap_cnt + 10'd1;

   // Slot movement first, then the spawn search sees slots freed by retirement this tick
   always_comb begin
      pos_mv    = pos_q;
      active_mv = active_q;
      spawn_idx = 2'd0;
      spawn_en  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (active_q[i]) begin
            if (pos_q[i] == RETIRE_POS) begin
               active_mv[i] = 1'b0;
               pos_mv[i]    = 12'd0;
            end else begin
               pos_mv[i] = pos_q[i] + 12'd1;
            end
         end
      end
      for (int i = 3; i >= 0; i--) begin
         if (!active_mv[i]) spawn_idx = 2'(i);
      end
      spawn_en = (gap_inc >= req_gap) && (active_mv != 4'hF);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= 1'b0;
         period_q <= START_P;
         tick_cnt <= 18'd0;
         ramp_cnt <= '0;
         gap_cnt  <= 10'd0;
         req_gap  <= GAP_MIN;
         pos_q    <= '0;
         active_q <= 4'd0;
      end else begin
         sync_q <= tick_fire;
         if (game_init) begin
            period_q <= START_P;
            tick_cnt <= 18'd0;
            ramp_cnt <= '0;
            gap_cnt  <= GAP_MIN;
            req_gap  <= GAP_MIN;
            pos_q    <= '0;
            active_q <= 4'd0;
         end else if (run_step) begin
            tick_cnt <= tick_fire ? 18'd0 : tick_cnt + 18'd1;
            ramp_cnt <= ramp_fire ? '0 : ramp_cnt + RAMP_W'(1);
            if (ramp_fire) period_q <= period_ramped;
            if (tick_fire) begin
               pos_q    <= pos_mv;
               active_q <= active_mv;
               gap_cnt  <= gap_inc;
               if (spawn_en) begin
                  pos_q[spawn_idx]    <= SPAWN_POS;
                  active_q[spawn_idx] <= 1'b1;
                  gap_cnt             <= 10'd0;
                  req_gap             <= GAP_MIN + {1'b0, bus.random_input};
               end
            end
         end
      end
   end

   assign bus.cactus0       = pos_q[0];
   assign bus.cactus1       = pos_q[1];
   assign bus.cactus2       = pos_q[2];
   assign bus.cactus3       = pos_q[3];
   assign bus.cactus_active = active_q;
   assign bus.cactus_sync   = sync_q;
   assign bus.state         = state_q;
   assign bus.period        = period_q;
endmodule
